// File: rtl/clken_bank.sv
// Bank of independent programmable clock-enable generators. Each channel divides
// i_clk by its own divisor and emits a one-cycle tick plus a 50% square wave.
module clken_bank #(
    parameter int                       N_CH    = 3,
    parameter int                       WIDTH   = 16,
    parameter logic [N_CH*WIDTH-1:0]    RST_DIV = {N_CH{WIDTH'(1)}},
    parameter logic [N_CH-1:0]          RST_EN  = '1
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic                                  i_wr,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] i_wr_ch,
    input  logic [WIDTH-1:0]                      i_wr_div,
    input  logic                                  i_wr_mode,
    input  logic                                  i_wr_en,
    input  logic                                  i_sync,
    output logic [N_CH-1:0]                       o_tick,
    output logic [N_CH-1:0]                       o_sq,
    output logic [N_CH-1:0]                       o_busy
);

    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

    // Writes addressed past the last channel are dropped entirely.
    logic wr_ok;
    assign wr_ok = i_wr && ({1'b0, i_wr_ch} < (CW + 1)'(N_CH));

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        localparam logic [WIDTH-1:0] RDIV = RST_DIV[c*WIDTH +: WIDTH];

        logic [WIDTH-1:0] div_q, div_d;
        logic [WIDTH-1:0] cnt_q, cnt_d;
        logic             mode_q, mode_d;
        logic             run_q, run_d;
        logic             tick_q, tick_d;
        logic             sq_q, sq_d;
        logic             wr_hit;

        assign wr_hit = wr_ok && (i_wr_ch == CW'(c));

        // A write overrides both sync and a pending tick on its own channel.
        always_comb begin
            div_d  = div_q;
            cnt_d  = cnt_q;
            mode_d = mode_q;
            run_d  = run_q;
            sq_d   = sq_q;
            tick_d = 1'b0;
            if (wr_hit) begin
                div_d  = i_wr_div;
                mode_d = i_wr_mode;
                run_d  = i_wr_en && (i_wr_div != '0);
                cnt_d  = i_wr_div - WIDTH'(1);
                sq_d   = 1'b0;
            end else if (run_q) begin
                if (i_sync) begin
                    cnt_d = div_q - WIDTH'(1);
                end else if (cnt_q == '0) begin
                    cnt_d  = div_q - WIDTH'(1);
                    tick_d = 1'b1;
                    sq_d   = ~sq_q;
                    if (mode_q) begin
                        run_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - WIDTH'(1);
                end
            end
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                div_q  <= RDIV;
                cnt_q  <= RDIV - WIDTH'(1);
                mode_q <= 1'b0;
                run_q  <= RST_EN[c] && (RDIV != '0);
                tick_q <= 1'b0;
                sq_q   <= 1'b0;
            end else begin
                div_q  <= div_d;
                cnt_q  <= cnt_d;
                mode_q <= mode_d;
                run_q  <= run_d;
                tick_q <= tick_d;
                sq_q   <= sq_d;
            end
        end

        assign o_tick[c] = tick_q;
        assign o_sq[c]   = sq_q;
        assign o_busy[c] = run_q;
    end

endmodule

// File: tb/tb_clken_bank.sv
// Self-checking bench for clken_bank: an edge-indexed reference model predicts
// {busy,sq,tick} for every channel; predictions are queued and compared per edge.
module tb_clken_bank;

    localparam int N_CH  = 3;
    localparam int WIDTH = 16;
    localparam logic [N_CH*WIDTH-1:0] RST_DIV = {16'd4, 16'd3, 16'd2};
    localparam logic [N_CH-1:0]       RST_EN  = 3'b111;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_wr;
    logic [1:0]       i_wr_ch;
    logic [WIDTH-1:0] i_wr_div;
    logic             i_wr_mode;
    logic             i_wr_en;
    logic             i_sync;
    logic [N_CH-1:0]  o_tick;
    logic [N_CH-1:0]  o_sq;
    logic [N_CH-1:0]  o_busy;

    clken_bank #(
        .N_CH(N_CH), .WIDTH(WIDTH), .RST_DIV(RST_DIV), .RST_EN(RST_EN)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr(i_wr), .i_wr_ch(i_wr_ch),
        .i_wr_div(i_wr_div), .i_wr_mode(i_wr_mode), .i_wr_en(i_wr_en),
        .i_sync(i_sync), .o_tick(o_tick), .o_sq(o_sq), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int e       = 0;
    int anc[N_CH];
    int dv[N_CH];
    bit md[N_CH];
    bit rn[N_CH];
    bit sq0[N_CH];
    logic [3*N_CH-1:0] exp_q[$];

    // Expected {busy,sq,tick} of channel c after edge ee; edge anc[c] is the
    // write/sync/reset edge, first tick dv[c] edges later.
    function automatic logic [2:0] model(int c, int ee);
        int j;
        j = ee - anc[c];
        if (!rn[c]) return {1'b0, sq0[c], 1'b0};
        if (md[c]) return {j < dv[c], sq0[c] ^ (j >= dv[c]), j == dv[c]};
        return {1'b1, sq0[c] ^ (((j / dv[c]) % 2) == 1), (j > 0) && (j % dv[c] == 0)};
    endfunction

    function automatic logic [3*N_CH-1:0] model_vec(int ee);
        logic [N_CH-1:0] b, s, t;
        logic [2:0] m;
        for (int c = 0; c < N_CH; c++) begin
            m = model(c, ee);
            b[c] = m[2];
            s[c] = m[1];
            t[c] = m[0];
        end
        return {b, s, t};
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            anc[c] = e;
            dv[c]  = int'(RST_DIV[c*WIDTH +: WIDTH]);
            md[c]  = 1'b0;
            rn[c]  = RST_EN[c] && (dv[c] != 0);
            sq0[c] = 1'b0;
        end
    endtask

    // One clock edge: drive inputs, predict, clock, compare.
    task automatic step(input bit wr, input int ch, input int dval,
                        input bit mode, input bit en, input bit sync);
        logic [2:0] m;
        logic [3*N_CH-1:0] got, want;
        i_wr      = wr;
        i_wr_ch   = ch[1:0];
        i_wr_div  = dval[WIDTH-1:0];
        i_wr_mode = mode;
        i_wr_en   = en;
        i_sync    = sync;
        if (sync) begin
            for (int c = 0; c < N_CH; c++) begin
                if (!(wr && ch == c)) begin
                    m = model(c, e);
                    if (m[2]) begin
                        sq0[c] = m[1];
                        anc[c] = e + 1;
                    end
                end
            end
        end
        if (wr && ch < N_CH) begin
            anc[ch] = e + 1;
            dv[ch]  = dval;
            md[ch]  = mode;
            rn[ch]  = en && (dval != 0);
            sq0[ch] = 1'b0;
        end
        exp_q.push_back(model_vec(e + 1));
        @(posedge clk);
        e++;
        #1;
        i_wr   = 1'b0;
        i_sync = 1'b0;
        got  = {o_busy, o_sq, o_tick};
        want = exp_q.pop_front();
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL edge%0d {busy,sq,tick}: got %b expected %b", e, got, want);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_in_reset(input string tag);
        logic [3*N_CH-1:0] got, want;
        got  = {o_busy, o_sq, o_tick};
        want = {RST_EN, {N_CH{1'b0}}, {N_CH{1'b0}}};
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s {busy,sq,tick}: got %b expected %b", tag, got, want);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check_in_reset("reset_hold");
        end
        rst_n = 1'b1;
        model_reset();
        idle(24);
    endtask

    task automatic test_oneshot();
        step(1'b1, 1, 5, 1'b1, 1'b1, 1'b0);
        idle(12);
    endtask

    task automatic test_zero_div();
        step(1'b1, 0, 0, 1'b0, 1'b1, 1'b0);
        idle(100);
        step(1'b1, 0, 1, 1'b0, 1'b1, 1'b0);
        idle(10);
    endtask

    task automatic test_sync();
        step(1'b1, 0, 7, 1'b0, 1'b1, 1'b0);
        step(1'b1, 2, 3, 1'b0, 1'b1, 1'b0);
        idle(4);
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        idle(44);
        step(1'b1, 1, 4, 1'b0, 1'b1, 1'b1);
        idle(12);
    endtask

    task automatic test_write_on_tick();
        logic [2:0] m;
        int t;
        t = 0;
        for (int k = 1; k <= 10 && t == 0; k++) begin
            m = model(2, e + k);
            if (m[0]) t = k;
        end
        if (t > 1) idle(t - 1);
        step(1'b1, 2, 6, 1'b0, 1'b1, 1'b0);
        idle(14);
        step(1'b1, 3, 9, 1'b1, 1'b0, 1'b0);
        idle(10);
    endtask

    task automatic test_reset_mid();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_in_reset("reset_async");
        repeat (3) begin
            @(posedge clk);
            #1;
            check_in_reset("reset_mid_hold");
        end
        rst_n = 1'b1;
        model_reset();
        idle(20);
    endtask

    task automatic test_max_div();
        step(1'b1, 2, 65535, 1'b0, 1'b1, 1'b0);
        idle(65538);
    endtask

    initial begin
        rst_n     = 1'b0;
        i_wr      = 1'b0;
        i_wr_ch   = '0;
        i_wr_div  = '0;
        i_wr_mode = 1'b0;
        i_wr_en   = 1'b0;
        i_sync    = 1'b0;
        model_reset();
        test_reset();
        test_oneshot();
        test_zero_div();
        test_sync();
        test_write_on_tick();
        test_reset_mid();
        test_max_div();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
